// File: rtl/bus_arb4.sv
// Four-source round-robin bus arbiter with registered active-low driver
// enables, a one-cycle turnaround slot and an optional hold limit.
module bus_arb4 #(
    parameter int MAXHOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] g_,
    output logic [1:0] owner,
    output logic       busy,
    output logic       turn
);

    localparam int CW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam int LIMI = (MAXHOLD == 0) ? (2 ** CW) - 1 : MAXHOLD - 1;
    localparam logic [CW-1:0] LIM = LIMI[CW-1:0];
    localparam bit LIMITED = (MAXHOLD != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    owner_q, owner_d;
    logic [3:0]    g_q, g_d;
    logic          busy_q, busy_d;
    logic          turn_q, turn_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       others;
    logic       expired;

    // Rotating-priority scan starting at ptr_q
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign others  = |(req & ~(4'b0001 << owner_q));
    assign expired = LIMITED && (cnt_q == LIM) && others;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    state_d = OWN;
                    owner_d = win;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!req[owner_q] || expired) begin
                    state_d = TURN;
                    ptr_d   = owner_q + 2'd1;
                end else if (cnt_q != LIM) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        g_d    = (state_d == OWN) ? ~(4'b0001 << owner_d) : 4'b1111;
        busy_d = (state_d == OWN);
        turn_d = (state_d == TURN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            g_q     <= 4'b1111;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
        end
    end

    assign g_    = g_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign turn  = turn_q;

endmodule

// File: tb/tb_bus_arb4.sv
// Directed bench for bus_arb4: vector table plus hand-written
// sequences for round-robin rotation and the unlimited-hold variant.
module tb_bus_arb4;

    logic       clk = 1'b0;
    logic       reset, reset0;
    logic [3:0] req, req0;
    logic [3:0] g_, g0_;
    logic [1:0] owner, owner0;
    logic       busy, busy0, turn, turn0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arb4 #(.MAXHOLD(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .g_(g_), .owner(owner), .busy(busy), .turn(turn)
    );

    bus_arb4 #(.MAXHOLD(0)) dut0 (
        .clk(clk), .reset(reset0), .req(req0),
        .g_(g0_), .owner(owner0), .busy(busy0), .turn(turn0)
    );

    typedef struct {
        bit         rst;
        logic [3:0] rq;
        logic [3:0] g;
        logic [1:0] o;
        bit         b;
        bit         t;
    } vec_t;

    vec_t vq[$];

    function automatic void add(bit r, logic [3:0] q, logic [3:0] g,
                                logic [1:0] o, bit b, bit t);
        vec_t v;
        v.rst = r; v.rq = q; v.g = g; v.o = o; v.b = b; v.t = t;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (g_,owner,busy,turn)",
                     name, act, exp);
        end
    endtask

    task automatic step(bit r, logic [3:0] q);
        @(negedge clk);
        reset = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    task automatic step0(bit r, logic [3:0] q);
        @(negedge clk);
        reset0 = r;
        req0   = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req = '0; reset0 = 1'b1; req0 = '0;

        // reset, reset overriding requests
        add(1, 4'b0000, 4'b1111, 2'd0, 0, 0);
        add(1, 4'b0110, 4'b1111, 2'd0, 0, 0);
        // first grant to source 1, held 8 cycles, then turnaround, then 2
        for (int i = 0; i < 8; i++) add(0, 4'b0110, 4'b1101, 2'd1, 1, 0);
        add(0, 4'b0110, 4'b1111, 2'd1, 0, 1);
        add(0, 4'b0110, 4'b1011, 2'd2, 1, 0);
        // reset mid-OWN releases immediately, no TURN
        add(1, 4'b0100, 4'b1111, 2'd0, 0, 0);
        add(0, 4'b0100, 4'b1011, 2'd2, 1, 0);
        // owner drops, ptr=3, then source 0 wins after wrap
        add(0, 4'b0001, 4'b1111, 2'd2, 0, 1);
        for (int i = 0; i < 20; i++) add(0, 4'b0001, 4'b1110, 2'd0, 1, 0);
        add(0, 4'b0000, 4'b1111, 2'd0, 0, 1);
        add(0, 4'b0000, 4'b1111, 2'd0, 0, 0);
        // ptr=1: owner 3, releases, ptr wraps to 0
        add(0, 4'b1000, 4'b0111, 2'd3, 1, 0);
        add(0, 4'b1001, 4'b0111, 2'd3, 1, 0);
        add(0, 4'b0001, 4'b1111, 2'd3, 0, 1);
        add(0, 4'b1001, 4'b1110, 2'd0, 1, 0);
        // owner 0 drops in the same cycle its hold expires
        for (int i = 0; i < 7; i++) add(0, 4'b0011, 4'b1110, 2'd0, 1, 0);
        add(0, 4'b0010, 4'b1111, 2'd0, 0, 1);
        add(0, 4'b0010, 4'b1101, 2'd1, 1, 0);
        add(0, 4'b0000, 4'b1111, 2'd1, 0, 1);
        add(0, 4'b0000, 4'b1111, 2'd1, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].rq);
            chk($sformatf("vec%0d", i), {g_, owner, busy, turn},
                {vq[i].g, vq[i].o, vq[i].b, vq[i].t});
        end

        // all four requesting: rotation 0,1,2,3,0 with one TURN between
        step(1, 4'b1111);
        chk("rr_reset", {g_, owner, busy, turn}, {4'b1111, 2'd0, 1'b0, 1'b0});
        for (int k = 0; k < 5; k++) begin
            logic [1:0] o;
            logic [3:0] one;
            o   = 2'(k);
            one = 4'b0001 << o;
            for (int c = 0; c < 8; c++) begin
                step(0, 4'b1111);
                chk($sformatf("rr_own%0d_c%0d", k, c), {g_, owner, busy, turn},
                    {~one, o, 1'b1, 1'b0});
                n_cmp++;
                if ($countones(~g_) > 1) begin
                    n_bad++;
                    $display("FAIL rr_onehot: got g_=%b want at most one low", g_);
                end
            end
            if (k < 4) begin
                step(0, 4'b1111);
                chk($sformatf("rr_turn%0d", k), {g_, owner, busy, turn},
                    {4'b1111, o, 1'b0, 1'b1});
            end
        end

        // unlimited hold keeps source 0 despite source 1 waiting
        step0(1, 4'b0011);
        chk("u_reset", {g0_, owner0, busy0, turn0}, {4'b1111, 2'd0, 1'b0, 1'b0});
        for (int c = 0; c < 50; c++) begin
            step0(0, 4'b0011);
            chk($sformatf("u_hold%0d", c), {g0_, owner0, busy0, turn0},
                {4'b1110, 2'd0, 1'b1, 1'b0});
        end
        step0(0, 4'b0010);
        chk("u_rel", {g0_, owner0, busy0, turn0}, {4'b1111, 2'd0, 1'b0, 1'b1});
        step0(0, 4'b0010);
        chk("u_next", {g0_, owner0, busy0, turn0}, {4'b1101, 2'd1, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
